// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB/FAULT) with memory handshakes and ready timeout.
// Define INSTR_COUNT_EN to enable the retired-instruction counter on instr_count_o; otherwise it is tied to 0.
module multicycle_control #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             reset_l_i,
    input  logic [10:0]      opcode_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             zero_i,
    output logic             imem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             reg2loc_o,
    output logic             alusrc_o,
    output logic             mem2reg_o,
    output logic             branch_o,
    output logic             uncond_branch_o,
    output logic [3:0]       aluop_o,
    output logic [2:0]       signop_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic             regwrite_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] instr_count_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_MOVZ, C_LDUR, C_STUR, C_B, C_CBZ, C_ILL} cls_t;

    state_t      state_q;
    cls_t        cls_q, cls_d;
    logic [11:0] sel_q, sel_d, sel_o;
    logic [15:0] tmo_q;
    logic        waiting, expired, run;

    // Selects packed as {reg2loc, alusrc, mem2reg, branch, uncond_branch, aluop[3:0], signop[2:0]}; first match wins
    always_comb begin
        cls_d = C_ILL;
        sel_d = '0;
        casez (opcode_i)
            11'b??111000010: begin cls_d = C_LDUR; sel_d = {5'b01100, 4'b0010, 3'b010}; end
            11'b??111000000: begin cls_d = C_STUR; sel_d = {5'b11000, 4'b0010, 3'b010}; end
            11'b?0?01011???: begin cls_d = C_R;    sel_d = {5'b00000, 4'b0010, 3'b000}; end
            11'b?1?01011???: begin cls_d = C_R;    sel_d = {5'b00000, 4'b0110, 3'b000}; end
            11'b?0?10001???: begin cls_d = C_I;    sel_d = {5'b01000, 4'b0010, 3'b011}; end
            11'b?1?10001???: begin cls_d = C_I;    sel_d = {5'b01000, 4'b0110, 3'b011}; end
            11'b?0001010???: begin cls_d = C_R;    sel_d = {5'b00000, 4'b0000, 3'b000}; end
            11'b?0101010???: begin cls_d = C_R;    sel_d = {5'b00000, 4'b0001, 3'b000}; end
            11'b110100101??: begin cls_d = C_MOVZ; sel_d = {5'b01000, 4'b0111, opcode_i[2:0]}; end
            11'b?00101?????: begin cls_d = C_B;    sel_d = {5'b00001, 4'b0000, 3'b000}; end
            11'b?011010????: begin cls_d = C_CBZ;  sel_d = {5'b10010, 4'b0111, 3'b001}; end
            default:         begin cls_d = C_ILL;  sel_d = '0; end
        endcase
    end

    assign waiting = (state_q == S_FETCH && !imem_ready_i) || (state_q == S_MEM && !dmem_ready_i);
    assign expired = waiting && tmo_q == 16'(TIMEOUT - 1);

    // Phase sequencing; the wait counter restarts whenever the FSM is not stalled on a memory
    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            state_q <= S_FETCH;
            cls_q   <= C_R;
            sel_q   <= '0;
            tmo_q   <= '0;
        end else begin
            tmo_q <= waiting ? tmo_q + 16'd1 : 16'd0;
            case (state_q)
                S_FETCH:  state_q <= imem_ready_i ? S_DECODE : expired ? S_FAULT : S_FETCH;
                S_DECODE: begin
                    cls_q   <= cls_d;
                    sel_q   <= sel_d;
                    state_q <= (cls_d == C_ILL) ? S_FAULT : S_EXEC;
                end
                S_EXEC:   state_q <= (cls_q == C_B || cls_q == C_CBZ) ? S_FETCH :
                                     (cls_q == C_LDUR || cls_q == C_STUR) ? S_MEM : S_WB;
                S_MEM:    state_q <= dmem_ready_i ? ((cls_q == C_LDUR) ? S_WB : S_FETCH) : expired ? S_FAULT : S_MEM;
                S_WB:     state_q <= S_FETCH;
                default:  state_q <= S_FAULT;
            endcase
        end
    end

    // Strobes are forced low while reset is asserted so nothing leaks out during reset
    assign run             = reset_l_i;
    assign imem_req_o      = run && state_q == S_FETCH;
    assign ir_write_o      = imem_req_o && imem_ready_i;
    assign pc_write_o      = run && ((state_q == S_EXEC && (cls_q == C_B || cls_q == C_CBZ)) ||
                                     (state_q == S_MEM && cls_q == C_STUR && dmem_ready_i) ||
                                     state_q == S_WB);
    assign pc_src_o        = run && state_q == S_EXEC && (cls_q == C_B || (cls_q == C_CBZ && zero_i));
    assign memread_o       = run && state_q == S_MEM && cls_q == C_LDUR;
    assign memwrite_o      = run && state_q == S_MEM && cls_q == C_STUR;
    assign regwrite_o      = run && state_q == S_WB;
    assign fault_o         = state_q == S_FAULT;
    assign sel_o           = (state_q == S_DECODE) ? sel_d :
                             (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) ? sel_q : '0;
    assign {reg2loc_o, alusrc_o, mem2reg_o, branch_o, uncond_branch_o, aluop_o, signop_o} = sel_o;

`ifdef INSTR_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Retired-instruction count: one pc_write per instruction, wraps naturally
    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) cnt_q <= '0;
        else if (pc_write_o) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign instr_count_o = cnt_q;
`else
    assign instr_count_o = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multi-cycle sequencer with TIMEOUT=4, CNT_W=4.
module tb_multicycle_control;
    localparam logic [10:0] ADDREG = 11'b10001011000;
    localparam logic [10:0] LDUR   = 11'b11111000010;
    localparam logic [10:0] STUR   = 11'b11111000000;
    localparam logic [10:0] CBZ    = 11'b10110100000;
    localparam logic [10:0] BR     = 11'b00010100000;
    localparam logic [10:0] MOVZ   = 11'b11010010110;
    localparam logic [10:0] ADDIMM = 11'b10010001000;

    logic        clk = 1'b0, rst_l = 1'b0;
    logic [10:0] opcode = '0;
    logic        imem_ready = 1'b1, dmem_ready = 1'b1, zero = 1'b0;
    logic        imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg, branch, uncond;
    logic [3:0]  aluop;
    logic [2:0]  signop;
    logic        memread, memwrite, regwrite, fault;
    logic [3:0]  instr_count;
    int          errors = 0, checks = 0, cnt_en;

    multicycle_control #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i(clk), .reset_l_i(rst_l), .opcode_i(opcode), .imem_ready_i(imem_ready),
        .dmem_ready_i(dmem_ready), .zero_i(zero), .imem_req_o(imem_req), .ir_write_o(ir_write),
        .pc_write_o(pc_write), .pc_src_o(pc_src), .reg2loc_o(reg2loc), .alusrc_o(alusrc),
        .mem2reg_o(mem2reg), .branch_o(branch), .uncond_branch_o(uncond), .aluop_o(aluop),
        .signop_o(signop), .memread_o(memread), .memwrite_o(memwrite), .regwrite_o(regwrite),
        .fault_o(fault), .instr_count_o(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
`ifdef INSTR_COUNT_EN
        cnt_en = 1;
`else
        cnt_en = 0;
`endif
        #3;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_fault", fault, 0);
        chk("rst_aluop", aluop, 0);
        chk("rst_count", instr_count, 0);
        // ADDREG, ready tied high
        step; rst_l = 1'b1; opcode = ADDREG; #1;
        chk("add_c1_imem_req", imem_req, 1);
        chk("add_c1_ir_write", ir_write, 1);
        step;
        chk("add_c2_aluop", aluop, 4'b0010);
        chk("add_c2_ir_write", ir_write, 0);
        step;
        chk("add_c3_pc_write", pc_write, 0);
        step;
        chk("add_c4_regwrite", regwrite, 1);
        chk("add_c4_pc_write", pc_write, 1);
        chk("add_c4_pc_src", pc_src, 0);
        chk("add_c4_aluop", aluop, 4'b0010);
        chk("add_c4_alusrc", alusrc, 0);
        // LDUR with three slow data-memory cycles
        step; opcode = LDUR; #1;
        chk("ldr_c1_ir_write", ir_write, 1);
        step;
        chk("ldr_c2_mem2reg", mem2reg, 1);
        chk("ldr_c2_signop", signop, 3'b010);
        chk("ldr_c2_alusrc", alusrc, 1);
        step; dmem_ready = 1'b0; #1;
        chk("ldr_c3_memread", memread, 0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("ldr_mem_wait_memread", memread, 1);
            chk("ldr_mem_wait_pc_write", pc_write, 0);
        end
        step; dmem_ready = 1'b1; #1;
        chk("ldr_c7_memread", memread, 1);
        chk("ldr_c7_fault", fault, 0);
        step;
        chk("ldr_c8_regwrite", regwrite, 1);
        chk("ldr_c8_pc_write", pc_write, 1);
        chk("ldr_c8_mem2reg", mem2reg, 1);
        chk("ldr_c8_memread", memread, 0);
        // CBZ taken then not taken
        step; opcode = CBZ; zero = 1'b1; #1;
        step;
        chk("cbz1_branch", branch, 1);
        chk("cbz1_reg2loc", reg2loc, 1);
        step;
        chk("cbz1_pc_write", pc_write, 1);
        chk("cbz1_pc_src", pc_src, 1);
        chk("cbz1_regwrite", regwrite, 0);
        step; zero = 1'b0; #1;
        chk("cbz_next_fetch", imem_req, 1);
        step;
        step;
        chk("cbz0_pc_write", pc_write, 1);
        chk("cbz0_pc_src", pc_src, 0);
        chk("cbz0_regwrite", regwrite, 0);
        // STUR, B, MOVZ
        step; opcode = STUR; #1;
        step;
        chk("stur_reg2loc", reg2loc, 1);
        chk("stur_mem2reg", mem2reg, 0);
        step;
        step;
        chk("stur_memwrite", memwrite, 1);
        chk("stur_pc_write", pc_write, 1);
        chk("stur_pc_src", pc_src, 0);
        chk("stur_regwrite", regwrite, 0);
        step; opcode = BR; #1;
        step;
        chk("b_uncond", uncond, 1);
        step;
        chk("b_pc_write", pc_write, 1);
        chk("b_pc_src", pc_src, 1);
        step; opcode = MOVZ; #1;
        step;
        chk("movz_signop", signop, 3'b110);
        chk("movz_aluop", aluop, 4'b0111);
        step;
        chk("movz_alusrc", alusrc, 1);
        step;
        chk("movz_regwrite", regwrite, 1);
        chk("movz_pc_write", pc_write, 1);
        // Fetch timeout: four low cycles then FAULT
        step; imem_ready = 1'b0; #1;
        chk("count_after7", instr_count, cnt_en ? 7 : 0);
        chk("tmo_w1_fault", fault, 0);
        chk("tmo_w1_imem_req", imem_req, 1);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("tmo_wait_fault", fault, 0);
            chk("tmo_wait_imem_req", imem_req, 1);
        end
        step;
        chk("tmo_fault", fault, 1);
        chk("tmo_imem_req", imem_req, 0);
        imem_ready = 1'b1; #1;
        chk("tmo_fault_ir_write", ir_write, 0);
        rst_l = 1'b0; #1;
        chk("tmo_rst_fault", fault, 0);
        // Ready on the 4th cycle is accepted, then 17 ADDIMM wrap the 4-bit counter
        step; rst_l = 1'b1; imem_ready = 1'b0; opcode = ADDIMM; #1;
        chk("addi_rst_count", instr_count, 0);
        step;
        step;
        step; imem_ready = 1'b1; #1;
        chk("addi_late_ir_write", ir_write, 1);
        chk("addi_late_fault", fault, 0);
        step;
        chk("addi_signop", signop, 3'b011);
        chk("addi_alusrc", alusrc, 1);
        chk("addi_fault", fault, 0);
        step;
        step;
        chk("addi_pc_write", pc_write, 1);
        for (int i = 0; i < 16; i++) begin
            step;
            step;
            step;
            step;
            chk("addi_loop_pc_write", pc_write, 1);
        end
        // Illegal opcode
        step; opcode = 11'b00000000000; #1;
        chk("count_wrap", instr_count, cnt_en ? 1 : 0);
        chk("ill_ir_write", ir_write, 1);
        step;
        chk("ill_dec_pc_write", pc_write, 0);
        chk("ill_dec_fault", fault, 0);
        step;
        chk("ill_fault", fault, 1);
        chk("ill_pc_write", pc_write, 0);
        chk("ill_regwrite", regwrite, 0);
        chk("ill_imem_req", imem_req, 0);
        step;
        chk("ill_sticky", fault, 1);
        rst_l = 1'b0; #1;
        chk("ill_rst_fault", fault, 0);
        chk("ill_rst_imem_req", imem_req, 0);
        // Reset aborting a STUR mid-MEM
        step; rst_l = 1'b1; opcode = STUR; dmem_ready = 1'b0; #1;
        chk("rel_imem_req", imem_req, 1);
        chk("rel_fault", fault, 0);
        step;
        step;
        step;
        chk("abort_memwrite", memwrite, 1);
        chk("abort_pc_write", pc_write, 0);
        #2 rst_l = 1'b0; #1;
        chk("abort_rst_memwrite", memwrite, 0);
        chk("abort_rst_count", instr_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
